// File: rtl/pulse_load_seq.sv
// pulse_load_seq: a small FIFO of pulse counts that feeds a downstream pulse generator. The
// block keeps a shadow copy of the downstream down-counter. It issues the next queued count
// so that each new burst starts right as the previous one finishes.
//
// Parameters
//   DW  width of a pulse count
//   AW  queue address width; the queue holds 2**AW entries
//
// Ports
//   clk     single clock; all state changes on its rising edge
//   rst_n   asynchronous active-low reset
//   in_vld  upstream count valid
//   in_rdy  queue can accept a count (~full)
//   in_dat  requested pulse count
//   ld_dat  count presented to the pulse generator (0 when lden is low)
//   lden    one-cycle load strobe to the pulse generator
//   busy    queue non-empty or a burst still in progress
//   level   number of queued entries
//
// Configuration
//   PULSE_LOAD_GAP_EN  when defined, a count is issued only once the shadow counter reaches 0.
//                      This puts one idle cycle between consecutive non-zero bursts. By default
//                      issue happens at sh <= 1, so bursts run back to back.

module pulse_load_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    output logic [DW-1:0] ld_dat,
    output logic          lden,
    output logic          busy,
    output logic [AW:0]   level
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] sh_q, sh_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;
    logic issue;

    // in_rdy depends only on the stored level. A pop in the same cycle never frees a slot early.
    assign full      = (level_q == (AW+1)'(Depth));
    assign not_empty = (level_q != '0);
    assign push      = in_vld & ~full;

    // Issue is decided from flops only, so no path exists from in_vld or in_dat to lden.
`ifdef PULSE_LOAD_GAP_EN
    assign issue = not_empty & (sh_q == '0);
`else
    assign issue = not_empty & (sh_q <= DW'(1));
`endif

    assign pop = issue;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        sh_d    = sh_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        // Shadow of the downstream counter: load on strobe, otherwise count down to 0.
        if (issue) begin
            sh_d = mem_q[head_q];
        end else if (sh_q != '0) begin
            sh_d = sh_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            sh_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            sh_q    <= sh_d;
        end
    end

    // Storage needs no reset: a stale entry is never visible because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_dat;
        end
    end

    assign in_rdy = ~full;
    assign lden   = issue;
    assign ld_dat = issue ? mem_q[head_q] : '0;
    assign busy   = (sh_q != '0) | not_empty;
    assign level  = level_q;

endmodule

// File: tb/tb_pulse_load_seq.sv
module tb_pulse_load_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_dat;
    logic [DW-1:0] ld_dat;
    logic          lden;
    logic          busy;
    logic [AW:0]   level;

    int n_chk;
    int n_fail;

    pulse_load_seq #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_vld(in_vld),
        .in_rdy(in_rdy),
        .in_dat(in_dat),
        .ld_dat(ld_dat),
        .lden  (lden),
        .busy  (busy),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          rdy;
        logic          lden;
        logic [DW-1:0] ld;
        logic          busy;
        logic [AW:0]   level;
    } vec_t;

    vec_t tbl [20];

    // Scoreboard for the random stream
    logic          mon_en;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    always @(posedge clk) begin
        if (mon_en && rst_n) begin
            if (in_vld && in_rdy) exp_q.push_back(in_dat);
            if (lden) got_q.push_back(ld_dat);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input int d, input logic r, input logic l,
                           input int ld, input logic b, input int lv);
        tbl[i].vld   = v;
        tbl[i].dat   = DW'(d);
        tbl[i].rdy   = r;
        tbl[i].lden  = l;
        tbl[i].ld    = DW'(ld);
        tbl[i].busy  = b;
        tbl[i].level = (AW+1)'(lv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        in_dat = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int   cnt;
    int   sum_e;
    int   sum_g;
    logic seen;
    logic [2:0] fill_lvl [7];
    logic       fill_rdy [7];
    logic       fill_ld  [7];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        in_dat = '0;

        // Outputs while reset is held
        #12;
        chk("rst_lden", 32'(lden), 0);
        chk("rst_ld_dat", 32'(ld_dat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);

        // Single burst of 3, gapless 2-then-4, and the zero-count case
        //         vld dat rdy lden ld busy lvl
        set_vec(0, 1, 3, 1, 0, 0, 0, 0);
        set_vec(1, 0, 0, 1, 1, 3, 1, 1);
        set_vec(2, 0, 0, 1, 0, 0, 1, 0);
        set_vec(3, 0, 0, 1, 0, 0, 1, 0);
        set_vec(4, 0, 0, 1, 0, 0, 1, 0);
        set_vec(5, 0, 0, 1, 0, 0, 0, 0);
        set_vec(6, 1, 2, 1, 0, 0, 0, 0);
        set_vec(7, 1, 4, 1, 1, 2, 1, 1);
        set_vec(8, 0, 0, 1, 0, 0, 1, 1);
        set_vec(9, 0, 0, 1, 1, 4, 1, 1);
        set_vec(10, 0, 0, 1, 0, 0, 1, 0);
        set_vec(11, 0, 0, 1, 0, 0, 1, 0);
        set_vec(12, 0, 0, 1, 0, 0, 1, 0);
        set_vec(13, 0, 0, 1, 0, 0, 1, 0);
        set_vec(14, 0, 0, 1, 0, 0, 0, 0);
        set_vec(15, 1, 0, 1, 0, 0, 0, 0);
        set_vec(16, 1, 1, 1, 1, 0, 1, 1);
        set_vec(17, 0, 0, 1, 1, 1, 1, 1);
        set_vec(18, 0, 0, 1, 0, 0, 1, 0);
        set_vec(19, 0, 0, 1, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_vld = tbl[i].vld;
            in_dat = tbl[i].dat;
            #1;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_lden", i), 32'(lden), 32'(tbl[i].lden));
            chk($sformatf("v%0d_ld_dat", i), 32'(ld_dat), 32'(tbl[i].ld));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].level));
        end

        // Fill to full while busy; push during a same-cycle pop on a full queue is rejected
        fill_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3};
        fill_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        fill_ld  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        @(negedge clk);
        in_vld = 1'b1;
        in_dat = DW'(5);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("full%0d_level", i), 32'(level), 32'(fill_lvl[i]));
            chk($sformatf("full%0d_in_rdy", i), 32'(in_rdy), 32'(fill_rdy[i]));
            chk($sformatf("full%0d_lden", i), 32'(lden), 32'(fill_ld[i]));
        end
        in_vld = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (lden) begin
                cnt++;
                chk("drain_ld_dat", 32'(ld_dat), 5);
            end
            if (!busy) break;
        end
        chk("drain_count", 32'(cnt), 3);
        chk("drain_busy", 32'(busy), 0);
        chk("drain_level", 32'(level), 0);

        // Reset mid-burst: 7,7,7 queued, reset asserted once the shadow count reaches 4
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_vld = 1'b1;
            in_dat = DW'(7);
        end
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_level", 32'(level), 2);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_lden", 32'(lden), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_rdy", 32'(in_rdy), 1);
        chk("arst_ld_dat", 32'(ld_dat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (lden || busy) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 0);
        in_vld = 1'b1;
        in_dat = DW'(1);
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        chk("post_rst_lden", 32'(lden), 1);
        chk("post_rst_ld_dat", 32'(ld_dat), 1);

        // Random stream across pointer wrap
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_vld = 1'($urandom_range(0, 1));
            in_dat = DW'($urandom_range(0, 6));
        end
        @(negedge clk);
        in_vld = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rand_drained", 32'(seen), 1);
        @(negedge clk);
        mon_en = 1'b0;
        sum_e = 0;
        sum_g = 0;
        foreach (exp_q[i]) sum_e += int'(exp_q[i]);
        foreach (got_q[i]) sum_g += int'(got_q[i]);
        chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
        chk("rand_sum", 32'(sum_g), 32'(sum_e));
        cnt = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) cnt++;
        end
        chk("rand_order_errors", 32'(cnt), 0);
        chk("rand_nonempty", 32'(exp_q.size() > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
